// File: rtl/mem_line_pkg.sv
// mem_line_pkg: shared FSM states and line-geometry defaults for the memory line master.
package mem_line_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;
  localparam int DEF_LINE_WORDS = 8;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int IDX_W = $clog2(DEF_LINE_WORDS);
  localparam int LINE_AW = DEF_ADDR_WIDTH - 2 - IDX_W;
endpackage

// File: rtl/mem_word_counter.sv
// mem_word_counter: modulo-N word index counter with start load, increment and terminal flags.
module mem_word_counter
  import mem_line_pkg::*;
#(
  parameter int N = DEF_LINE_WORDS,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] start_i,
  input  logic         inc_i,
  output logic [W-1:0] idx_o,
  output logic         last_o,
  output logic         done_o
);
  logic [W:0] cnt_q;
  logic [W-1:0] start_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      start_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
      start_q <= start_i;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  // index wraps inside the line; the extra count bit only marks completion
  assign idx_o = start_q + cnt_q[W-1:0];
  assign last_o = cnt_q == (W+1)'(N - 1);
  assign done_o = cnt_q[W];
endmodule

// File: rtl/mem_line_master.sv
// mem_line_master: sequences one cache-line refill/writeback as single-word memory transactions.
// Critical-word-first issue order is enabled by defining MEM_LINE_CRITICAL_WORD_FIRST_EN.
module mem_line_master
  import mem_line_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  localparam int IW = $clog2(LINE_WORDS),
  localparam int AW = ADDR_WIDTH - 2 - IW,
  localparam int LB = LINE_WORDS * WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [AW-1:0]         req_line_addr,
  input  logic [IW-1:0]         req_word_offset,
  input  logic [LB-1:0]         req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [LB-1:0]         resp_rdata,
  output logic [WORD_WIDTH-1:0] mem_write_data,
  output logic [ADDR_WIDTH-3:0] mem_write_addr,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-3:0] mem_read_addr,
  output logic                  mem_read_addr_valid,
  input  logic                  mem_read_ready,
  input  logic [WORD_WIDTH-1:0] mem_read_data,
  input  logic                  mem_read_valid
);
  state_e state_q, state_d;
  logic [AW-1:0] line_q;
  logic [LB-1:0] wdata_q, rdata_q;
  logic [IW-1:0] start, iss_idx, rcv_idx;
  logic accept, iss_inc, rcv_inc, iss_last, iss_done, iss_done_n, rcv_last, rcv_done_unused;

`ifdef MEM_LINE_CRITICAL_WORD_FIRST_EN
  assign start = req_word_offset;
`else
  logic unused_offset;
  assign start = '0;
  assign unused_offset = ^req_word_offset;
`endif

  assign req_ready = state_q == IDLE;
  assign accept = req_ready && req_valid;
  assign iss_done_n = !iss_done;
  assign mem_read_addr_valid = state_q == RD && iss_done_n;
  assign iss_inc = state_q == WR || (mem_read_addr_valid && mem_read_ready);
  assign rcv_inc = state_q == RD && mem_read_valid;
  assign mem_read_addr = {line_q, iss_idx};
  assign mem_write_addr = {line_q, iss_idx};
  assign mem_write_en = state_q == WR;
  assign mem_write_data = wdata_q[iss_idx*WORD_WIDTH +: WORD_WIDTH];
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;

  mem_word_counter #(.N(LINE_WORDS)) u_iss (
    .clk(clk), .rst(rst), .load_i(accept), .start_i(start), .inc_i(iss_inc),
    .idx_o(iss_idx), .last_o(iss_last), .done_o(iss_done)
  );

  mem_word_counter #(.N(LINE_WORDS)) u_rcv (
    .clk(clk), .rst(rst), .load_i(accept), .start_i(start), .inc_i(rcv_inc),
    .idx_o(rcv_idx), .last_o(rcv_last), .done_o(rcv_done_unused)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = req_valid ? (req_we ? WR : RD) : IDLE;
      RD: state_d = (rcv_inc && rcv_last) ? RESP : RD;
      WR: state_d = iss_last ? RESP : WR;
      RESP: state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      line_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        line_q <= req_line_addr;
        wdata_q <= req_wdata;
      end
      if (rcv_inc) rdata_q[rcv_idx*WORD_WIDTH +: WORD_WIDTH] <= mem_read_data;
    end
endmodule

// File: tb/tb_mem_line_master.sv
// tb_mem_line_master: randomized line refill/writeback bench against a queue-based memory model.
module tb_mem_line_master;
  localparam int WW = 32, AW = 32, L = 8, IW = 3, LAW = AW - 2 - IW, LB = L * WW;

  logic clk = 0, rst;
  logic req_valid, req_ready, req_we, resp_valid, resp_ready;
  logic [LAW-1:0] req_line_addr;
  logic [IW-1:0] req_word_offset;
  logic [LB-1:0] req_wdata, resp_rdata;
  logic [WW-1:0] mem_write_data, mem_read_data;
  logic [AW-3:0] mem_write_addr, mem_read_addr;
  logic mem_write_en, mem_read_addr_valid, mem_read_ready, mem_read_valid;

  int n_chk = 0, n_err = 0;
  logic [WW-1:0] salt = '0;
  logic inject = 0;
  logic [LB-1:0] prev_rdata = '0;

  mem_line_master dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_line_addr(req_line_addr), .req_word_offset(req_word_offset), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .mem_write_data(mem_write_data), .mem_write_addr(mem_write_addr), .mem_write_en(mem_write_en),
    .mem_read_addr(mem_read_addr), .mem_read_addr_valid(mem_read_addr_valid),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data), .mem_read_valid(mem_read_valid)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [WW-1:0] mem_word(input logic [AW-3:0] a);
    return WW'(a) ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory: returns the word one cycle after the accepting edge; inject forces a stray return
  initial begin
    logic f, inj;
    logic [AW-3:0] a;
    mem_read_valid = 0;
    mem_read_data = '0;
    forever begin
      @(negedge clk);
      f = mem_read_addr_valid && mem_read_ready && !rst;
      inj = inject;
      a = mem_read_addr;
      @(posedge clk);
      #1;
      mem_read_valid = f | inj;
      mem_read_data = inj ? 32'hDEADBEEF : mem_word(a);
    end
  end

  task automatic chk_reset(input string p);
    chk({p, "_req_ready"}, req_ready, 1);
    chk({p, "_resp_valid"}, resp_valid, 0);
    chk({p, "_resp_rdata"}, resp_rdata, 0);
    chk({p, "_write_en"}, mem_write_en, 0);
    chk({p, "_addr_valid"}, mem_read_addr_valid, 0);
    chk({p, "_read_addr"}, mem_read_addr, 0);
    chk({p, "_write_addr"}, mem_write_addr, 0);
    chk({p, "_write_data"}, mem_write_data, 0);
  endtask

  task automatic run_txn(input bit we, input logic [LAW-1:0] line, input logic [IW-1:0] off,
                         input logic [LB-1:0] wd, input logic [31:0] stall, input int rdly);
    logic [IW-1:0] st;
    logic [LB-1:0] exp_line, snap;
    logic [AW-3:0] got_a[$];
    logic [WW-1:0] got_d[$];
    int k, t_resp, exp_t, issued, j;
    bit busy_ok, stable_ok, wr_ok;
`ifdef MEM_LINE_CRITICAL_WORD_FIRST_EN
    st = off;
`else
    st = '0;
`endif
    exp_line = prev_rdata;
    if (!we) for (int i = 0; i < L; i++) exp_line[i*WW +: WW] = mem_word({line, IW'(i)});
    exp_t = -1;
    if (we) exp_t = L + 1;
    else begin
      issued = 0;
      for (int c = 1; c < 200 && issued < L; c++)
        if (c >= 32 || !stall[c]) begin
          issued++;
          if (issued == L) exp_t = c + 2;
        end
    end
    @(posedge clk);
    #1;
    req_valid = 1;
    req_we = we;
    req_line_addr = line;
    req_word_offset = off;
    req_wdata = wd;
    mem_read_ready = 1;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    busy_ok = 1;
    wr_ok = 1;
    t_resp = -1;
    k = 0;
    while (t_resp < 0 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
      req_valid = 0;
      mem_read_ready = (k < 32) ? !stall[k] : 1'b1;
      @(negedge clk);
      if (req_ready) busy_ok = 0;
      if (mem_read_addr_valid && mem_read_ready) begin
        if (we) wr_ok = 0;
        got_a.push_back(mem_read_addr);
      end
      if (mem_write_en) begin
        if (!we || k != got_d.size() + 1) wr_ok = 0;
        got_a.push_back(mem_write_addr);
        got_d.push_back(mem_write_data);
      end
      if (resp_valid) t_resp = k;
    end
    mem_read_ready = 1;
    chk("resp_cycle", t_resp, exp_t);
    chk("word_count", got_a.size(), L);
    for (int i = 0; i < got_a.size() && i < L; i++) chk("word_addr", got_a[i], {line, IW'(st + i)});
    if (we)
      for (int i = 0; i < got_d.size() && i < L; i++) begin
        j = (st + i) % L;
        chk("wr_data", got_d[i], wd[j*WW +: WW]);
      end
    chk("wr_timing", wr_ok, 1);
    chk("rdata", resp_rdata, exp_line);
    snap = resp_rdata;
    stable_ok = 1;
    repeat (rdly) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (!resp_valid || resp_rdata !== snap || req_ready) stable_ok = 0;
    end
    chk("resp_stable", stable_ok, 1);
    @(posedge clk);
    #1;
    resp_ready = 1;
    @(posedge clk);
    #1;
    resp_ready = 0;
    @(negedge clk);
    chk("req_ready_after", req_ready, 1);
    chk("resp_valid_after", resp_valid, 0);
    chk("busy_req_ready", busy_ok, 1);
    prev_rdata = exp_line;
  endtask

  task automatic reset_mid_refill(input logic [LAW-1:0] line);
    int fires, k;
    @(posedge clk);
    #1;
    req_valid = 1;
    req_we = 0;
    req_line_addr = line;
    req_word_offset = 3'd2;
    mem_read_ready = 1;
    fires = 0;
    k = 0;
    while (fires < 3 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
      req_valid = 0;
      @(negedge clk);
      if (mem_read_addr_valid && mem_read_ready) fires++;
    end
    chk("rst_three_issued", fires, 3);
    @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    chk_reset("midrst");
    @(posedge clk);
    #1;
    rst = 0;
    inject = 1;
    prev_rdata = '0;
    @(negedge clk);
    #1;
    inject = 0;
    @(posedge clk);
    @(negedge clk);
    chk("late_valid_seen", mem_read_valid, 1);
    @(posedge clk);
    @(negedge clk);
    chk_reset("after_late");
  endtask

  initial begin
    logic [LB-1:0] wd;
    rst = 1;
    req_valid = 0;
    req_we = 0;
    req_line_addr = '0;
    req_word_offset = '0;
    req_wdata = '0;
    resp_ready = 0;
    mem_read_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk);
    #1;
    rst = 0;

    run_txn(0, 27'h10, 3'd0, '0, 32'h0, 0);
    chk("refill_slot0", resp_rdata[WW-1:0], 32'h80);
    for (int i = 0; i < L; i++) wd[i*WW +: WW] = 32'hA0 + i;
    run_txn(1, 27'h3, 3'd0, wd, 32'h0, 1);
    run_txn(0, 27'h55, 3'd0, '0, 32'h1C, 0);
    salt = 32'h1234_0000;
    run_txn(0, 27'h7, 3'd5, '0, 32'h0, 5);
    run_txn(1, 27'h9, 3'd6, {8{32'hC0DE_0001}} ^ wd, 32'h0, 5);
    reset_mid_refill(27'h21);
    run_txn(0, 27'h21, 3'd1, '0, 32'h0, 0);

    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < L; i++) wd[i*WW +: WW] = $urandom;
      salt = $urandom;
      run_txn(1'($urandom_range(0, 1)), LAW'($urandom), IW'($urandom), wd,
              $urandom & $urandom, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
